matrix_deserialiser: RTL and testbench

- Inverse of the matrix-to-byte serialiser. Accepts a byte stream under a valid/ready handshake and packs 64 bytes into one 4x4 matrix of 32-bit words, i.e. one ChaCha20 state or keystream block.
- Presents the completed matrix under a second valid/ready handshake.
- Sits between a byte-wide source (received ciphertext/keystream buffer) and the block-level datapath.

---
 rtl/matrix_deserialiser.sv | 123 ++++++++++++
 tb/tb_matrix_deserialiser.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_deserialiser.sv
// Packs a byte stream into a 4x4 matrix of 32-bit words (little-endian), handed on under valid/ready.
// Optional ZEROPAD_EN: matrix cleared on byte 0, in_last closes a partial matrix early.
module matrix_deserialiser #(
   parameter int DATA_SIZE    = 8,
   parameter int NUM_MATRICES = 2,
   parameter int WORDS        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [DATA_SIZE-1:0]   in_byte,
   input  logic                   in_last,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0][3:0][31:0]  out_matrix,
   output logic                   out_frame_last,
   output logic [5:0]             byte_cnt
);
   localparam int            FW        = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1;
   localparam logic [FW-1:0] FRAME_MAX = FW'(NUM_MATRICES - 1);
   localparam logic [5:0]    LAST_IDX  = 6'(WORDS * 4 - 1);
   localparam logic [0:0]    S_FILL    = 1'b0;
   localparam logic [0:0]    S_HOLD    = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [5:0]            cnt_q, cnt_d;
   logic [FW-1:0]         frame_q, frame_d;
   logic [3:0][3:0][31:0] mat_q, mat_d;
   logic                  flast_q;
   logic                  en_q;
   logic                  accept;
   logic                  xfer;

`ifdef ZEROPAD_EN
   // Set when in_last closed the matrix early; the frame restarts after it is handed on.
   logic                  early_q, early_d;
`else
   logic                  unused_in_last;
   assign unused_in_last = in_last;
`endif

   // en_q holds in_ready low until the first edge after reset release.
   assign in_ready       = (state_q == S_FILL) && en_q && !flush;
   assign accept         = in_valid && in_ready;
   assign xfer           = (state_q == S_HOLD) && out_ready && !flush;
   assign out_valid      = (state_q == S_HOLD);
   assign out_matrix     = mat_q;
   assign out_frame_last = flast_q;
   assign byte_cnt       = cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      mat_d   = mat_q;
`ifdef ZEROPAD_EN
      early_d = early_q;
`endif
      if (flush) begin
         state_d = S_FILL;
         cnt_d   = '0;
         frame_d = '0;
`ifdef ZEROPAD_EN
         early_d = 1'b0;
`endif
      end else if (accept) begin
`ifdef ZEROPAD_EN
         if (cnt_q == '0) begin
            mat_d = '0;
         end
`endif
         mat_d[cnt_q[5:4]][cnt_q[3:2]][{cnt_q[1:0], 3'b000} +: 8] = in_byte[7:0];
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == LAST_IDX) begin
            state_d = S_HOLD;
            cnt_d   = '0;
         end
`ifdef ZEROPAD_EN
         else if (in_last) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            early_d = 1'b1;
         end
`endif
      end else if (xfer) begin
         state_d = S_FILL;
         frame_d = (frame_q == FRAME_MAX) ? '0 : frame_q + FW'(1);
`ifdef ZEROPAD_EN
         if (early_q) begin
            frame_d = '0;
         end
         early_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         frame_q <= '0;
         mat_q   <= '0;
         flast_q <= 1'b0;
         en_q    <= 1'b0;
`ifdef ZEROPAD_EN
         early_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         mat_q   <= mat_d;
         flast_q <= (frame_d == FRAME_MAX);
         en_q    <= 1'b1;
`ifdef ZEROPAD_EN
         early_q <= early_d;
`endif
      end
   end

endmodule

// File: tb/tb_matrix_deserialiser.sv
// Scoreboard bench for matrix_deserialiser: expected matrices queued at stimulus, popped on output.
module tb_matrix_deserialiser;
   localparam int NUM_MATRICES = 2;

   typedef logic [3:0][3:0][31:0] mat_t;
   typedef struct packed {
      mat_t m;
      logic last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_byte = 8'h00;
   logic       in_last = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   mat_t       out_matrix;
   logic       out_frame_last;
   logic [5:0] byte_cnt;

   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   logic [7:0] pat[64];
   int         exp_frame = 0;

   matrix_deserialiser #(
      .DATA_SIZE(8),
      .NUM_MATRICES(NUM_MATRICES),
      .WORDS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_byte(in_byte),
      .in_last(in_last),
      .in_ready(in_ready),
      .flush(flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_matrix(out_matrix),
      .out_frame_last(out_frame_last),
      .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   function automatic mat_t build_exp(input int n);
      mat_t m;
      m = '0;
      for (int w = 0; w < 16; w++)
         for (int b = 0; b < 4; b++)
            if (4 * w + b < n) m[w / 4][w % 4][8 * b +: 8] = pat[4 * w + b];
      return m;
   endfunction

   function automatic exp_t make_entry(input int n);
      exp_t e;
      e.m    = build_exp(n);
      e.last = (exp_frame == NUM_MATRICES - 1);
      return e;
   endfunction

   // Offers pat[start .. start+n-1]; gap is the percentage of idle cycles. Called at posedge+1.
   task automatic send_bytes(input int start, input int n, input int gap, input bit last_at_end);
      int  idx;
      int  guard;
      bit  took;
      idx   = 0;
      guard = 0;
      while (idx < n && guard < 2000) begin
         in_valid = ($urandom_range(99) >= gap);
         in_byte  = pat[start + idx];
         in_last  = last_at_end && (idx == n - 1);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (took) idx++;
         guard++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (idx < n) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, n);
      end
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic xfer_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      exp_frame = (exp_frame + 1) % NUM_MATRICES;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (byte_cnt !== 6'd0) begin errors++; $display("FAIL rst_byte_cnt: got %0d expected 0", byte_cnt); end
      checks++; if (out_matrix !== '0) begin errors++; $display("FAIL rst_matrix: got %h expected 0", out_matrix); end
      checks++; if (out_frame_last !== 1'b0) begin errors++; $display("FAIL rst_frame_last: got %b expected 0", out_frame_last); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_early: got %b expected 0", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_rise: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      exp_t e;
      for (int i = 0; i < 64; i++) pat[i] = 8'(i);
      sb.push_back(make_entry(64));
      out_ready = 1'b1;
      send_bytes(0, 64, 0, 1'b0);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b expected 1", out_valid); end
      e = sb.pop_front();
      checks++; if (out_matrix[0][0] !== 32'h03020100) begin errors++; $display("FAIL basic_w00: got %h expected 03020100", out_matrix[0][0]); end
      checks++; if (out_matrix[3][3] !== 32'h3F3E3D3C) begin errors++; $display("FAIL basic_w33: got %h expected 3f3e3d3c", out_matrix[3][3]); end
      checks++; if (out_matrix !== e.m) begin errors++; $display("FAIL basic_matrix: got %h expected %h", out_matrix, e.m); end
      checks++; if (out_frame_last !== 1'b0) begin errors++; $display("FAIL basic_frame_last: got %b expected 0", out_frame_last); end
      xfer_out();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   ok;
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
         sb.push_back(make_entry(64));
         @(posedge clk);
         #1;
         send_bytes(0, 64, 0, 1'b0);
         wait_out(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: matrix %0d out_valid 0 expected 1", m);
            void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            if (out_matrix !== e.m || out_frame_last !== e.last) begin
               errors++;
               $display("FAIL b2b_matrix%0d: got %h last %b expected %h last %b", m, out_matrix, out_frame_last, e.m, e.last);
            end
            xfer_out();
         end
      end
   endtask

   task automatic test_hold_backpressure();
      exp_t e;
      for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
      sb.push_back(make_entry(64));
      send_bytes(0, 64, 0, 1'b0);
      in_valid = 1'b1;
      in_byte  = 8'h55;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_matrix !== sb[0].m || byte_cnt !== 6'd0) begin
            errors++;
            $display("FAIL hold_cycle%0d: in_ready %b out_valid %b cnt %0d matrix %h expected 0 1 0 %h",
                     c, in_ready, out_valid, byte_cnt, out_matrix, sb[0].m);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++; if (out_frame_last !== e.last) begin errors++; $display("FAIL hold_frame_last: got %b expected %b", out_frame_last, e.last); end
      xfer_out();
      @(negedge clk);
      checks++; if (byte_cnt !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: cnt %0d out_valid %b expected 0 0", byte_cnt, out_valid); end
   endtask

   task automatic test_gaps();
      exp_t e;
      bit   ok;
      for (int i = 0; i < 64; i++) pat[i] = 8'(i);
      sb.push_back(make_entry(64));
      @(posedge clk);
      #1;
      send_bytes(0, 30, 50, 1'b0);
      @(negedge clk);
      checks++; if (byte_cnt !== 6'd30) begin errors++; $display("FAIL gaps_byte_cnt: got %0d expected 30", byte_cnt); end
      @(posedge clk);
      #1;
      send_bytes(30, 34, 50, 1'b0);
      wait_out(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_matrix !== e.m || out_frame_last !== e.last) begin
         errors++;
         $display("FAIL gaps_matrix: valid %b got %h last %b expected %h last %b", ok, out_matrix, out_frame_last, e.m, e.last);
      end
      if (ok) xfer_out();
   endtask

   task automatic test_flush();
      exp_t e;
      bit   ok;
      for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
      @(posedge clk);
      #1;
      send_bytes(0, 20, 0, 1'b0);
      @(negedge clk);
      checks++; if (byte_cnt !== 6'd20) begin errors++; $display("FAIL flush_pre_cnt: got %0d expected 20", byte_cnt); end
      @(posedge clk);
      #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_byte  = 8'hEE;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      exp_frame = 0;
      @(negedge clk);
      checks++; if (byte_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", byte_cnt); end
      for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
      sb.push_back(make_entry(64));
      @(posedge clk);
      #1;
      send_bytes(0, 64, 0, 1'b0);
      wait_out(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_matrix !== e.m || out_frame_last !== e.last) begin
         errors++;
         $display("FAIL flush_matrix: valid %b got %h last %b expected %h last %b", ok, out_matrix, out_frame_last, e.m, e.last);
      end
      // Flush while a matrix is held: it is discarded without a handshake.
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      exp_frame = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || byte_cnt !== 6'd0) begin errors++; $display("FAIL flush_hold: out_valid %b cnt %0d expected 0 0", out_valid, byte_cnt); end
   endtask

`ifdef ZEROPAD_EN
   task automatic test_zeropad();
      exp_t e;
      bit   ok;
      for (int i = 0; i < 64; i++) pat[i] = 8'hAA;
      sb.push_back(make_entry(5));
      @(posedge clk);
      #1;
      send_bytes(0, 5, 0, 1'b1);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zp_latency: out_valid %b expected 1", out_valid); end
      e = sb.pop_front();
      checks++; if (out_matrix[0][0] !== 32'hAAAAAAAA) begin errors++; $display("FAIL zp_w00: got %h expected aaaaaaaa", out_matrix[0][0]); end
      checks++; if (out_matrix[0][1] !== 32'h000000AA) begin errors++; $display("FAIL zp_w01: got %h expected 000000aa", out_matrix[0][1]); end
      checks++; if (out_matrix !== e.m) begin errors++; $display("FAIL zp_matrix: got %h expected %h", out_matrix, e.m); end
      checks++; if (byte_cnt !== 6'd0) begin errors++; $display("FAIL zp_cnt: got %0d expected 0", byte_cnt); end
      xfer_out();
      exp_frame = 0;
      for (int i = 0; i < 64; i++) pat[i] = 8'($urandom);
      sb.push_back(make_entry(64));
      send_bytes(0, 64, 0, 1'b0);
      wait_out(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_matrix !== e.m || out_frame_last !== e.last) begin
         errors++;
         $display("FAIL zp_after: valid %b got %h last %b expected %h last %b", ok, out_matrix, out_frame_last, e.m, e.last);
      end
      if (ok) xfer_out();
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hold_backpressure();
      test_gaps();
      test_flush();
`ifdef ZEROPAD_EN
      test_zeropad();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
